// File: rtl/order_fetch.sv
// Instruction fetch stage: owns the PC, fetches 8-bit words over a req/ack handshake and
// holds each one on ORDER until execute reports completion, then steps or jumps.
module order_fetch #(
   parameter int unsigned            ADDR_W     = 8,
   parameter logic [ADDR_W-1:0]      RESET_ADDR = '0
) (
   input  logic              CLK,
   input  logic              RESET,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic              MEM_REQ,
   input  logic              MEM_ACK,
   input  logic [7:0]        MEM_DATA,
   output logic [7:0]        ORDER,
   output logic              ORDER_VALID,
   input  logic              ORDER_DONE,
   input  logic              JUMP,
   input  logic [ADDR_W-1:0] JUMP_ADDR,
   input  logic              HALT,
   output logic [ADDR_W-1:0] PC
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic              mem_req_q;
   logic [7:0]        order_q;
   logic              order_valid_q;

   // JUMP only matters together with ORDER_DONE; the increment wraps naturally.
   always_comb begin
      pc_d = pc_q + ADDR_W'(1);
      if (JUMP) begin
         pc_d = JUMP_ADDR;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= StIdle;
         pc_q          <= RESET_ADDR;
         mem_req_q     <= 1'b0;
         order_q       <= 8'h00;
         order_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!HALT) begin
                  state_q   <= StFetch;
                  mem_req_q <= 1'b1;
               end
            end
            StFetch: begin
               if (MEM_ACK) begin
                  state_q       <= StHold;
                  order_q       <= MEM_DATA;
                  order_valid_q <= 1'b1;
                  mem_req_q     <= 1'b0;
               end
            end
            StHold: begin
               if (ORDER_DONE) begin
                  order_valid_q <= 1'b0;
                  pc_q          <= pc_d;
                  if (HALT) begin
                     state_q   <= StIdle;
                     mem_req_q <= 1'b0;
                  end else begin
                     state_q   <= StFetch;
                     mem_req_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q       <= StIdle;
               mem_req_q     <= 1'b0;
               order_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign MEM_ADDR    = pc_q;
   assign MEM_REQ     = mem_req_q;
   assign ORDER       = order_q;
   assign ORDER_VALID = order_valid_q;
   assign PC          = pc_q;

endmodule

// File: tb/tb_order_fetch.sv
// Directed bench for order_fetch: drives memory acks and execute handshakes by hand and
// compares PC, MEM_REQ/MEM_ADDR and ORDER against hand-computed values.
module tb_order_fetch;

   logic       clk;
   logic       reset;
   logic [7:0] mem_addr;
   logic       mem_req;
   logic       mem_ack;
   logic [7:0] mem_data;
   logic [7:0] order;
   logic       order_valid;
   logic       order_done;
   logic       jump;
   logic [7:0] jump_addr;
   logic       halt;
   logic [7:0] pc;

   int n_checks = 0;
   int n_pass   = 0;

   order_fetch #(
      .ADDR_W     (8),
      .RESET_ADDR (8'h00)
   ) dut (
      .CLK         (clk),
      .RESET       (reset),
      .MEM_ADDR    (mem_addr),
      .MEM_REQ     (mem_req),
      .MEM_ACK     (mem_ack),
      .MEM_DATA    (mem_data),
      .ORDER       (order),
      .ORDER_VALID (order_valid),
      .ORDER_DONE  (order_done),
      .JUMP        (jump),
      .JUMP_ADDR   (jump_addr),
      .HALT        (halt),
      .PC          (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ack_step(input logic [7:0] data);
      mem_ack  = 1'b1;
      mem_data = data;
      step();
      mem_ack  = 1'b0;
      mem_data = 8'h00;
   endtask

   task automatic done_step(input logic j, input logic [7:0] ja);
      order_done = 1'b1;
      jump       = j;
      jump_addr  = ja;
      step();
      order_done = 1'b0;
      jump       = 1'b0;
      jump_addr  = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset      = 1'b1;
      mem_ack    = 1'b0;
      mem_data   = 8'h00;
      order_done = 1'b0;
      jump       = 1'b0;
      jump_addr  = 8'h00;
      halt       = 1'b0;
      #1;
      step();
      step();
      check("rst_pc", pc, 8'h00);
      check("rst_req", mem_req, 1'b0);
      check("rst_valid", order_valid, 1'b0);
      check("rst_order", order, 8'h00);

      reset = 1'b0;
      step();
      check("start_req", mem_req, 1'b1);

      // Two wait cycles per fetch, DONE one cycle after ORDER_VALID.
      for (int a = 0; a < 4; a++) begin
         check("ws_addr", mem_addr, 32'(a));
         step();
         check("ws_req_w1", mem_req, 1'b1);
         step();
         check("ws_req_w2", mem_req, 1'b1);
         check("ws_addr_w2", mem_addr, 32'(a));
         ack_step(8'hA0 + 8'(a));
         check("ws_order", order, 32'(8'hA0 + 8'(a)));
         check("ws_valid", order_valid, 1'b1);
         check("ws_req_low", mem_req, 1'b0);
         step();
         check("ws_hold_order", order, 32'(8'hA0 + 8'(a)));
         done_step(1'b0, 8'h00);
         check("ws_valid_low", order_valid, 1'b0);
         check("ws_pc", pc, 32'(a + 1));
         check("ws_req_again", mem_req, 1'b1);
      end

      // ORDER_DONE outside HOLD is ignored.
      done_step(1'b1, 8'h99);
      check("done_in_fetch_pc", pc, 8'h04);

      // Zero-wait: one instruction per two cycles.
      ack_step(8'h14);
      check("zw_order", order, 8'h14);
      done_step(1'b0, 8'h00);
      check("zw_pc", pc, 8'h05);
      check("zw_req", mem_req, 1'b1);

      // Jump at PC=5; a JUMP pulse without DONE changes nothing.
      ack_step(8'h15);
      jump      = 1'b1;
      jump_addr = 8'h77;
      step();
      jump      = 1'b0;
      check("jump_nodone_pc", pc, 8'h05);
      check("jump_nodone_valid", order_valid, 1'b1);
      done_step(1'b1, 8'h40);
      check("jump_addr", mem_addr, 8'h40);
      check("jump_req", mem_req, 1'b1);
      ack_step(8'h50);
      check("jump_order", order, 8'h50);
      done_step(1'b0, 8'h00);
      check("after_jump_addr", mem_addr, 8'h41);

      // Wrap from 8'hFF to 0.
      ack_step(8'h51);
      done_step(1'b1, 8'hFF);
      check("wrap_pre_pc", pc, 8'hFF);
      ack_step(8'hEE);
      done_step(1'b0, 8'h00);
      check("wrap_pc", pc, 8'h00);
      check("wrap_req", mem_req, 1'b1);

      // HALT raised mid-FETCH: outstanding ack still accepted.
      halt = 1'b1;
      step();
      check("halt_fetch_req", mem_req, 1'b1);
      ack_step(8'h3C);
      check("halt_order", order, 8'h3C);
      check("halt_valid", order_valid, 1'b1);
      done_step(1'b0, 8'h00);
      check("halt_req_low", mem_req, 1'b0);
      check("halt_pc", pc, 8'h01);
      ack_step(8'h5A);
      check("ack_in_idle_order", order, 8'h3C);
      check("halt_idle_req", mem_req, 1'b0);
      halt = 1'b0;
      step();
      check("unhalt_req", mem_req, 1'b1);
      check("unhalt_addr", mem_addr, 8'h01);

      // Reset during FETCH at PC=7.
      ack_step(8'h61);
      done_step(1'b1, 8'h07);
      check("pre_rst_pc", pc, 8'h07);
      check("pre_rst_req", mem_req, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rstf_pc", pc, 8'h00);
      check("rstf_req", mem_req, 1'b0);
      check("rstf_valid", order_valid, 1'b0);
      step();
      check("rstf_refetch_req", mem_req, 1'b1);
      check("rstf_refetch_addr", mem_addr, 8'h00);

      // Reset during HOLD with simultaneous DONE/JUMP.
      ack_step(8'h70);
      check("rsth_valid_pre", order_valid, 1'b1);
      reset      = 1'b1;
      order_done = 1'b1;
      jump       = 1'b1;
      jump_addr  = 8'h33;
      step();
      reset      = 1'b0;
      order_done = 1'b0;
      jump       = 1'b0;
      jump_addr  = 8'h00;
      check("rsth_pc", pc, 8'h00);
      check("rsth_valid", order_valid, 1'b0);
      check("rsth_req", mem_req, 1'b0);
      check("rsth_order", order, 8'h00);
      step();
      check("rsth_refetch_req", mem_req, 1'b1);
      check("rsth_refetch_addr", mem_addr, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
